// File: rtl/apd_protection_ctrl.sv
// -----------------------------------------------------------------------------
// apd_protection_ctrl
//
// Multi-channel APD protection controller. Counts photon pulses per channel
// over a fixed window of clk cycles and gates the laser AOM drive when any
// channel count exceeds THRESH. After a trip it cools down with the laser off
// and re-probes for one window. It locks out after MAX_RETRY trips until an
// operator clear.
//
// Optional feature macro: APD_PROT_RATE_MON_EN
//   defined   : rate_max_o reports the highest channel count of the last
//               completed window.
//   undefined : rate_max_o is tied to 0 and no comparator tree is built.
//
// Ports:
//   clk_i         system clock
//   reset_n_i     asynchronous active-low reset
//   photon_i      asynchronous APD pulses, one bit per channel
//   laser_i       requested AOM drive
//   enable_i      protection active (0 = bypass)
//   clear_i       single-cycle operator re-arm
//   aomout_o      gated AOM drive (registered)
//   alarm_o       high in TRIPPED and LOCKED
//   locked_o      high in LOCKED
//   trip_ch_o     channels over threshold at the last trip (sticky until clear)
//   retry_cnt_o   trips since last clear or successful probe
//   rate_max_o    max channel count of the last completed window
//
// State table:
//   state       | meaning
//   ST_BYPASS   | protection off, aomout follows laser, counters held at 0
//   ST_ARMED    | counting windows, aomout follows laser
//   ST_TRIPPED  | laser off, cool-down timer running, photons ignored
//   ST_PROBE    | one trial window with laser on after cool-down
//   ST_LOCKED   | laser off until operator clear
// -----------------------------------------------------------------------------
module apd_protection_ctrl #(
    parameter int               NCH       = 2,
    parameter int               CNT_W     = 25,
    parameter int               WIN_LEN   = 8388608,
    parameter logic [CNT_W-1:0] THRESH    = CNT_W'(25'h0030000),
    parameter int               COOL_LEN  = 16777216,
    parameter int               MAX_RETRY = 3
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [NCH-1:0]   photon_i,
    input  logic             laser_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             aomout_o,
    output logic             alarm_o,
    output logic             locked_o,
    output logic [NCH-1:0]   trip_ch_o,
    output logic [3:0]       retry_cnt_o,
    output logic [CNT_W-1:0] rate_max_o
);

    localparam int WIN_W  = $clog2(WIN_LEN);
    localparam int COOL_W = (COOL_LEN > 1) ? $clog2(COOL_LEN) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOL_LEN - 1);

    typedef enum logic [2:0] {
        ST_BYPASS,
        ST_ARMED,
        ST_TRIPPED,
        ST_PROBE,
        ST_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [NCH-1:0]     sync1_q, sync2_q, sync3_q;
    logic [NCH-1:0]     pedge;
    logic [CNT_W-1:0]   cnt_q   [NCH];
    logic [CNT_W-1:0]   cnt_d   [NCH];
    logic [CNT_W-1:0]   cnt_inc [NCH];
    logic [NCH-1:0]     over_q, over_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [COOL_W-1:0]  cool_q, cool_d;
    logic [3:0]         retry_q, retry_d;
    logic [NCH-1:0]     trip_ch_q, trip_ch_d;
    logic               aomout_q, alarm_q, locked_q;
    logic               trip, win_term, cool_done, restart, count_en;
    logic [3:0]         retry_inc;

    // sync2 is the second synchronizer stage; sync3 only remembers its
    // previous value for rising-edge detection.
    assign pedge     = sync2_q & ~sync3_q;
    assign trip      = |over_q;
    assign win_term  = (win_q == WIN_LAST);
    assign cool_done = (cool_q == '0);
    assign retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        trip_ch_d = trip_ch_q;
        restart   = 1'b0;

        unique case (state_q)
            ST_BYPASS: begin
                if (enable_i) begin
                    state_d = ST_ARMED;
                    restart = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!enable_i) begin
                    state_d = ST_BYPASS;
                end else if (trip) begin
                    state_d   = ST_TRIPPED;
                    retry_d   = retry_inc;
                    trip_ch_d = over_q;
                end else if (clear_i) begin
                    restart   = 1'b1;
                    retry_d   = '0;
                    trip_ch_d = '0;
                end
            end
            ST_TRIPPED: begin
                if (!enable_i) begin
                    state_d = ST_BYPASS;
                end else if (clear_i) begin
                    state_d   = ST_ARMED;
                    restart   = 1'b1;
                    retry_d   = '0;
                    trip_ch_d = '0;
                end else if (cool_done) begin
                    state_d = (retry_q == 4'(MAX_RETRY)) ? ST_LOCKED : ST_PROBE;
                    restart = 1'b1;
                end
            end
            ST_PROBE: begin
                if (!enable_i) begin
                    state_d = ST_BYPASS;
                end else if (trip) begin
                    state_d   = ST_TRIPPED;
                    retry_d   = retry_inc;
                    trip_ch_d = over_q;
                end else if (clear_i) begin
                    state_d   = ST_ARMED;
                    restart   = 1'b1;
                    retry_d   = '0;
                    trip_ch_d = '0;
                end else if (win_term) begin
                    // Clean probe: the window wraps naturally into ARMED.
                    state_d = ST_ARMED;
                    retry_d = '0;
                end
            end
            ST_LOCKED: begin
                if (clear_i) begin
                    state_d   = ST_ARMED;
                    restart   = 1'b1;
                    retry_d   = '0;
                    trip_ch_d = '0;
                end
            end
            default: state_d = ST_BYPASS;
        endcase
    end

    // Counting continues only while staying in ARMED/PROBE without a restart.
    assign count_en = ((state_d == ST_ARMED) || (state_d == ST_PROBE)) && !restart;

    always_comb begin
        win_d = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_inc[c] = (pedge[c] && (cnt_q[c] != '1)) ? cnt_q[c] + 1'b1 : cnt_q[c];
            cnt_d[c]   = '0;
        end
        if (count_en) begin
            if (win_term) begin
                win_d = '0;
                for (int c = 0; c < NCH; c++)
                    cnt_d[c] = pedge[c] ? CNT_W'(1) : '0;
            end else begin
                win_d = win_q + 1'b1;
                for (int c = 0; c < NCH; c++)
                    cnt_d[c] = cnt_inc[c];
            end
        end
        // Compare against the next count so the register updates together
        // with the count; the state reacts one cycle later.
        for (int c = 0; c < NCH; c++)
            over_d[c] = (cnt_d[c] > THRESH);
    end

    always_comb begin
        cool_d = cool_q;
        if ((state_d == ST_TRIPPED) && (state_q != ST_TRIPPED))
            cool_d = COOL_LAST;
        else if ((state_q == ST_TRIPPED) && !cool_done)
            cool_d = cool_q - 1'b1;
    end

`ifdef APD_PROT_RATE_MON_EN
    logic [CNT_W-1:0] rate_q, rate_d, max_v;

    always_comb begin
        max_v = '0;
        for (int c = 0; c < NCH; c++)
            if (cnt_inc[c] > max_v)
                max_v = cnt_inc[c];
        rate_d = rate_q;
        if (state_d == ST_BYPASS)
            rate_d = '0;
        else if (((state_q == ST_ARMED) || (state_q == ST_PROBE)) && win_term)
            rate_d = max_v;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rate_q <= '0;
        else            rate_q <= rate_d;
    end

    assign rate_max_o = rate_q;
`else
    assign rate_max_o = '0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_BYPASS;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
            cnt_q     <= '{default: '0};
            over_q    <= '0;
            win_q     <= '0;
            cool_q    <= '0;
            retry_q   <= '0;
            trip_ch_q <= '0;
            aomout_q  <= 1'b0;
            alarm_q   <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= photon_i;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            cnt_q     <= cnt_d;
            over_q    <= over_d;
            win_q     <= win_d;
            cool_q    <= cool_d;
            retry_q   <= retry_d;
            trip_ch_q <= trip_ch_d;
            aomout_q  <= laser_i & ((state_d == ST_BYPASS) || (state_d == ST_ARMED) ||
                                    (state_d == ST_PROBE));
            alarm_q   <= (state_d == ST_TRIPPED) || (state_d == ST_LOCKED);
            locked_q  <= (state_d == ST_LOCKED);
        end
    end

    assign aomout_o    = aomout_q;
    assign alarm_o     = alarm_q;
    assign locked_o    = locked_q;
    assign trip_ch_o   = trip_ch_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_apd_protection_ctrl.sv
// Directed bench for apd_protection_ctrl. Main instance uses a short window
// and cool-down; a second instance with a 5-bit counter exercises saturation.
module tb_apd_protection_ctrl;

    localparam int NCH = 2;

`ifdef APD_PROT_RATE_MON_EN
    localparam bit RM = 1'b1;
`else
    localparam bit RM = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset_n, laser, enable, clear;
    logic [1:0]  photon;
    logic        aomout, alarm, locked;
    logic [1:0]  trip_ch;
    logic [3:0]  retry_cnt;
    logic [24:0] rate_max;

    logic        rst2_n, en2, laser2, clear2;
    logic [1:0]  ph2;
    logic        aom2, alarm2, locked2;
    logic [1:0]  trip_ch2;
    logic [3:0]  retry2;
    logic [4:0]  rate_max2;

    int n_chk = 0;
    int n_err = 0;

    apd_protection_ctrl #(
        .NCH(2), .CNT_W(25), .WIN_LEN(64), .THRESH(25'd10),
        .COOL_LEN(32), .MAX_RETRY(2)
    ) dut (
        .clk_i(clk_sys), .reset_n_i(reset_n), .photon_i(photon),
        .laser_i(laser), .enable_i(enable), .clear_i(clear),
        .aomout_o(aomout), .alarm_o(alarm), .locked_o(locked),
        .trip_ch_o(trip_ch), .retry_cnt_o(retry_cnt), .rate_max_o(rate_max)
    );

    apd_protection_ctrl #(
        .NCH(2), .CNT_W(5), .WIN_LEN(4096), .THRESH(5'h1F),
        .COOL_LEN(32), .MAX_RETRY(2)
    ) dut_sat (
        .clk_i(clk_sys), .reset_n_i(rst2_n), .photon_i(ph2),
        .laser_i(laser2), .enable_i(en2), .clear_i(clear2),
        .aomout_o(aom2), .alarm_o(alarm2), .locked_o(locked2),
        .trip_ch_o(trip_ch2), .retry_cnt_o(retry2), .rate_max_o(rate_max2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks and land 1 time unit after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m, input logic [1:0] m2);
        photon = m;
        ph2    = m2;
        cyc(1);
        photon = '0;
        ph2    = '0;
        cyc(1);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; laser = 1'b1; clear = 1'b0; photon = '0;
        rst2_n  = 1'b0; en2 = 1'b0; laser2 = 1'b1; clear2 = 1'b0; ph2 = '0;
        cyc(3);

        chk("rst_aomout", 32'(aomout), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_trip_ch", 32'(trip_ch), 32'd0);
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        chk("rst_rate_max", 32'(rate_max), 32'd0);

        reset_n = 1'b1;
        rst2_n  = 1'b1;
        cyc(1);                                 // ARMED, window phase 0
        chk("armed_aomout", 32'(aomout), 32'd1);

        // Low rate: 5 pulses per window on both channels.
        for (int w = 0; w < 10; w++) begin
            cyc(4);
            for (int i = 0; i < 5; i++) pulse(2'b11, 2'b00);
            cyc(50);                            // phase 0 of next window
            chk($sformatf("low_aomout_w%0d", w), 32'(aomout), 32'd1);
            chk($sformatf("low_alarm_w%0d", w), 32'(alarm), 32'd0);
            chk($sformatf("low_rate_w%0d", w), 32'(rate_max), RM ? 32'd5 : 32'd0);
        end

        // Edge detected in the terminal cycle starts the new window at 1.
        cyc(61);
        photon = 2'b01;
        cyc(1);
        photon = '0;
        cyc(2);
        chk("term_cnt0", 32'(dut.cnt_q[0]), 32'd1);
        chk("term_cnt1", 32'(dut.cnt_q[1]), 32'd0);
        chk("term_rate", 32'(rate_max), RM ? 32'd1 : 32'd0);

        // Trip on channel 1.
        for (int i = 0; i < 11; i++) pulse(2'b10, 2'b00);   // phase 22
        chk("pretrip_aomout", 32'(aomout), 32'd1);
        cyc(2);                                              // phase 24
        chk("trip_aomout", 32'(aomout), 32'd0);
        chk("trip_alarm", 32'(alarm), 32'd1);
        chk("trip_ch", 32'(trip_ch), 32'd2);
        chk("trip_retry", 32'(retry_cnt), 32'd1);
        chk("trip_locked", 32'(locked), 32'd0);
        cyc(31);
        chk("cool_last_aomout", 32'(aomout), 32'd0);
        cyc(1);
        chk("probe_aomout", 32'(aomout), 32'd1);
        chk("probe_alarm", 32'(alarm), 32'd0);
        chk("probe_retry", 32'(retry_cnt), 32'd1);

        // Clean probe window returns to ARMED.
        cyc(2);
        for (int i = 0; i < 3; i++) pulse(2'b01, 2'b00);
        cyc(55);
        chk("probe_end_retry", 32'(retry_cnt), 32'd1);
        cyc(1);
        chk("rearm_retry", 32'(retry_cnt), 32'd0);
        chk("rearm_aomout", 32'(aomout), 32'd1);
        chk("rearm_trip_ch", 32'(trip_ch), 32'd2);

        // Two trips in a row lead to LOCKED.
        for (int i = 0; i < 11; i++) pulse(2'b01, 2'b00);
        cyc(2);
        chk("trip1_retry", 32'(retry_cnt), 32'd1);
        chk("trip1_ch", 32'(trip_ch), 32'd1);
        cyc(32);
        chk("probe2_aomout", 32'(aomout), 32'd1);
        for (int i = 0; i < 11; i++) pulse(2'b10, 2'b00);
        cyc(2);
        chk("trip2_retry", 32'(retry_cnt), 32'd2);
        chk("trip2_alarm", 32'(alarm), 32'd1);
        chk("trip2_ch", 32'(trip_ch), 32'd2);
        cyc(32);
        chk("lock_locked", 32'(locked), 32'd1);
        chk("lock_alarm", 32'(alarm), 32'd1);
        chk("lock_aomout", 32'(aomout), 32'd0);
        cyc(100);
        chk("lock_hold_locked", 32'(locked), 32'd1);
        chk("lock_hold_aomout", 32'(aomout), 32'd0);
        enable = 1'b0;
        cyc(5);
        chk("lock_noen_locked", 32'(locked), 32'd1);
        chk("lock_noen_aomout", 32'(aomout), 32'd0);
        enable = 1'b1;
        clear  = 1'b1;
        cyc(1);
        clear  = 1'b0;
        chk("clr_locked", 32'(locked), 32'd0);
        chk("clr_alarm", 32'(alarm), 32'd0);
        chk("clr_retry", 32'(retry_cnt), 32'd0);
        chk("clr_trip_ch", 32'(trip_ch), 32'd0);
        chk("clr_aomout", 32'(aomout), 32'd1);

        // Clear in the trip cycle is dropped.
        for (int i = 0; i < 11; i++) pulse(2'b01, 2'b00);   // phase 22
        cyc(1);                                              // trip cycle
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("tripclr_alarm", 32'(alarm), 32'd1);
        chk("tripclr_aomout", 32'(aomout), 32'd0);
        chk("tripclr_retry", 32'(retry_cnt), 32'd1);
        chk("tripclr_ch", 32'(trip_ch), 32'd1);

        // Asynchronous reset in the middle of TRIPPED.
        cyc(10);
        enable  = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("arst_aomout", 32'(aomout), 32'd0);
        chk("arst_alarm", 32'(alarm), 32'd0);
        chk("arst_retry", 32'(retry_cnt), 32'd0);
        chk("arst_trip_ch", 32'(trip_ch), 32'd0);
        cyc(2);
        reset_n = 1'b1;

        // Bypass: aomout follows laser, nothing is counted.
        laser = 1'b0;
        cyc(2);
        chk("byp_aom_low", 32'(aomout), 32'd0);
        laser = 1'b1;
        cyc(1);
        chk("byp_aom_high", 32'(aomout), 32'd1);
        for (int i = 0; i < 20; i++) pulse(2'b11, 2'b00);
        cyc(4);
        chk("byp_alarm", 32'(alarm), 32'd0);
        chk("byp_aomout", 32'(aomout), 32'd1);
        chk("byp_cnt0", 32'(dut.cnt_q[0]), 32'd0);
        chk("byp_cnt1", 32'(dut.cnt_q[1]), 32'd0);
        chk("byp_rate", 32'(rate_max), 32'd0);

        // Saturation on the narrow-counter instance.
        en2 = 1'b1;
        cyc(1);
        for (int i = 0; i < 40; i++) pulse(2'b00, 2'b01);
        cyc(4);
        chk("sat_cnt0", 32'(dut_sat.cnt_q[0]), 32'h1F);
        chk("sat_cnt1", 32'(dut_sat.cnt_q[1]), 32'd0);
        chk("sat_alarm", 32'(alarm2), 32'd0);
        chk("sat_aomout", 32'(aom2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/apd_protection_ctrl.md
Name: apd_protection_ctrl

Overview:
- Multi-channel APD protection controller: counts photon pulses per channel over a fixed window of clk cycles and gates the laser AOM when any channel exceeds a rate threshold.
- After a trip, it cools down and re-probes automatically; it locks out after a bounded number of retries until an operator clear.
- Sits between the laser pattern source and the AOM driver; photon pulses come straight from the APD inputs.

Parameters:
- NCH, 2, number of APD channels.
- CNT_W, 25, per-channel photon counter width.
- WIN_LEN, 8388608, window length in clk cycles (>=4).
- THRESH, 25'h0030000, trip when a channel count > THRESH.
- COOL_LEN, 16777216, laser-off cycles after a trip (>=1).
- MAX_RETRY, 3, trips allowed before LOCKED (1..15).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- photon  in  NCH  asynchronous APD pulses, one bit per channel.
- laser  in  1  requested AOM drive.
- enable  in  1  protection active; 0 = bypass.
- clear  in  1  single-cycle operator re-arm.
- aomout  out  1  gated AOM drive.
- alarm  out  1  1 in TRIPPED, PROBE-fail or LOCKED.
- locked  out  1  1 in LOCKED.
- trip_ch  out  NCH  channels over threshold at the last trip (sticky until clear).
- retry_cnt  out  4  trips since last clear or successful probe.
- rate_max  out  CNT_W  max channel count of the last completed window (optional feature).

Behaviour:
- Reset: state BYPASS, all counters 0, aomout=0, alarm=0, locked=0, trip_ch=0, retry_cnt=0, rate_max=0.
- Photon input path:
  - Each photon bit passes through a 2-FF synchronizer plus rising-edge detect.
  - One count per rising edge; 3-cycle latency from the pin to the count increment.
  - Pulses shorter than one clk period may be lost; this is accepted.
- Counters:
  - Saturate at all-ones and never wrap.
  - Window counter runs 0..WIN_LEN-1 in ARMED and PROBE.
  - In the terminal cycle, channel counts reset to 0; an edge detected in that same cycle is counted as 1 in the new window.
- Trip compare:
  - Registered compare (count > THRESH) is evaluated every cycle, not only at window end.
  - A trip takes effect on the cycle after the count crosses THRESH.
  - aomout goes low in the same cycle the state becomes TRIPPED. aomout is registered: laser & gate.
- States:
  - BYPASS: aomout=laser, counters held at 0. enable=1 -> ARMED with window and counts reset.
  - ARMED: aomout=laser.
    - Trip -> TRIPPED: retry_cnt+1, trip_ch latched.
    - enable=0 -> BYPASS.
  - TRIPPED: aomout=0, alarm=1, cool counter runs COOL_LEN cycles, photons ignored.
    - At expiry: retry_cnt==MAX_RETRY -> LOCKED, else -> PROBE.
  - PROBE: aomout=laser, alarm=0, one full window.
    - Trip -> TRIPPED with retry_cnt+1.
    - Window completes clean -> ARMED with retry_cnt=0.
  - LOCKED: aomout=0, alarm=1, locked=1. Only clear leaves it.
- clear:
  - In any non-BYPASS state -> ARMED: retry_cnt=0, trip_ch=0, counters reset.
  - Trip and clear in the same cycle: trip wins and clear is dropped.
- enable:
  - enable=0 goes to BYPASS from every state except LOCKED; LOCKED needs clear first.
  - enable falling mid-TRIPPED -> BYPASS, retry_cnt kept.
- reset_n low at any time forces the reset values immediately (asynchronous).

Optional Feature:
- Macro: APD_PROT_RATE_MON_EN.
- Defined:
  - At each window terminal cycle, rate_max <= max over channels of the saturated counts, including the edge arriving in that cycle.
  - Held between windows.
  - Cleared to 0 on reset and in BYPASS.
- Undefined: rate_max tied to 0, no comparator tree synthesized.

Test Plan:
Bench parameters: NCH=2, WIN_LEN=64, THRESH=10, COOL_LEN=32, MAX_RETRY=2, enable=1, laser=1.
- Low rate: 5 pulses/window on both channels for 10 windows -> aomout stays 1, alarm=0, rate_max=5 after each window.
- Trip: 11 pulses on ch1 within 20 cycles -> aomout=0 within 4 cycles of the 11th pulse, trip_ch=2'b10, retry_cnt=1; aomout=1 again exactly 32 cycles later (PROBE).
- Probe and lockout: PROBE with 3 pulses -> ARMED, retry_cnt=0 after 64 cycles. Repeated trips -> second trip gives LOCKED, locked=1, aomout=0 indefinitely. clear -> ARMED, retry_cnt=0, trip_ch=0.
- Boundaries: clear asserted in the trip cycle -> state TRIPPED. Edge on the window terminal cycle -> new window count=1. 2^25 pulses with huge THRESH -> count saturates at 25'h1FFFFFF.
- reset_n pulsed low mid-TRIPPED -> aomout=0, alarm=0, state BYPASS.
- enable=0 -> aomout follows laser with no counting; enable=0 in LOCKED -> stays LOCKED.
